// File: rtl/tdp_ram_pkg.sv
// Shared types and helpers for the byte-enabled true dual-port RAM.
// byte_merge works on a wide container; callers cast to their width.
package tdp_ram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  localparam int MAX_W = 1024;
  localparam int MAX_B = MAX_W / 8;

  function automatic int nbytes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic logic [MAX_W-1:0] byte_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] wdata,
    input logic [MAX_B-1:0] be
  );
    logic [MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_B; i++) begin
      if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/tdp_ram_outpipe.sv
// Per-port read data / valid pipeline, one or two register stages.
// Data registers only load on a valid beat so rdata holds between reads.
module tdp_ram_outpipe
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int OUT_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  logic              s1_v_q, s1_v_d;
  logic [DATA_W-1:0] s1_d_q, s1_d_d;

  always_comb begin
    s1_v_d = in_vld;
    s1_d_d = in_vld ? in_data : s1_d_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_d_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;
      s1_d_q <= s1_d_d;
    end
  end

  if (OUT_REG != 0) begin : g_reg
    logic              s2_v_q, s2_v_d;
    logic [DATA_W-1:0] s2_d_q, s2_d_d;

    always_comb begin
      s2_v_d = s1_v_q;
      s2_d_d = s1_v_q ? s1_d_q : s2_d_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_v_q <= 1'b0;
        s2_d_q <= '0;
      end else begin
        s2_v_q <= s2_v_d;
        s2_d_q <= s2_d_d;
      end
    end

    assign out_vld  = s2_v_q;
    assign out_data = s2_d_q;
  end else begin : g_bypass
    assign out_vld  = s1_v_q;
    assign out_data = s1_d_q;
  end

endmodule

// File: rtl/tdp_ram_be.sv
// True dual-port RAM with byte enables, RDW mode and collision tracking.
// Same-address writes are merged per byte before reaching the array.
module tdp_ram_be
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int ADDR_W   = 3,
  parameter int RDW_MODE = 0,
  parameter int OUT_REG  = 0,
  parameter int PRIO_A   = 1,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_a,
  input  logic                     we_a,
  input  logic [DATA_W/8-1:0]      be_a,
  input  logic [ADDR_W-1:0]        addr_a,
  input  logic [DATA_W-1:0]        wdata_a,
  output logic [DATA_W-1:0]        rdata_a,
  output logic                     rvalid_a,
  input  logic                     en_b,
  input  logic                     we_b,
  input  logic [DATA_W/8-1:0]      be_b,
  input  logic [ADDR_W-1:0]        addr_b,
  input  logic [DATA_W-1:0]        wdata_b,
  output logic [DATA_W-1:0]        rdata_b,
  output logic                     rvalid_b,
  output logic                     collision,
  output logic [CNT_W-1:0]         coll_cnt,
  input  logic                     clr_cnt
);

  localparam int NB    = nbytes(DATA_W);
  localparam int DEPTH = 1 << ADDR_W;
  localparam rdw_mode_e MODE =
    (RDW_MODE != 0) ? WRITE_FIRST : READ_FIRST;

  function automatic logic [DATA_W-1:0] mrg(
    input logic [DATA_W-1:0] o,
    input logic [DATA_W-1:0] w,
    input logic [NB-1:0]     b
  );
    return DATA_W'(byte_merge(MAX_W'(o), MAX_W'(w), MAX_B'(b)));
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_a, wr_b, same;
  logic [NB-1:0]     ba, bb, ba_x, bb_x;
  logic [DATA_W-1:0] old_a, old_b;
  logic [DATA_W-1:0] new_a, new_b;
  logic [DATA_W-1:0] rd_a, rd_b;

  // Loser's bytes go in first so the winner's overwrite them.
  always_comb begin
    wr_a  = en_a & we_a;
    wr_b  = en_b & we_b;
    same  = (addr_a == addr_b);
    ba    = wr_a ? be_a : '0;
    bb    = wr_b ? be_b : '0;
    ba_x  = same ? ba : '0;
    bb_x  = same ? bb : '0;
    old_a = mem_q[addr_a];
    old_b = mem_q[addr_b];
    if (PRIO_A != 0) begin
      new_a = mrg(mrg(old_a, wdata_b, bb_x), wdata_a, ba);
      new_b = mrg(mrg(old_b, wdata_b, bb), wdata_a, ba_x);
    end else begin
      new_a = mrg(mrg(old_a, wdata_a, ba), wdata_b, bb_x);
      new_b = mrg(mrg(old_b, wdata_a, ba_x), wdata_b, bb);
    end
    rd_a = (MODE == WRITE_FIRST) ? new_a : old_a;
    rd_b = (MODE == WRITE_FIRST) ? new_b : old_b;
  end

  always_ff @(posedge clk) begin
    if (wr_a) mem_q[addr_a] <= new_a;
    if (wr_b) mem_q[addr_b] <= new_b;
  end

  logic             coll_q, coll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    coll_d = en_a & en_b & same & (we_a | we_b);
    cnt_d  = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (coll_d && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coll_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      coll_q <= coll_d;
      cnt_q  <= cnt_d;
    end
  end

  assign collision = coll_q;
  assign coll_cnt  = cnt_q;

  tdp_ram_outpipe #(
    .DATA_W (DATA_W),
    .OUT_REG(OUT_REG)
  ) u_pipe_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (en_a),
    .in_data (rd_a),
    .out_vld (rvalid_a),
    .out_data(rdata_a)
  );

  tdp_ram_outpipe #(
    .DATA_W (DATA_W),
    .OUT_REG(OUT_REG)
  ) u_pipe_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (en_b),
    .in_data (rd_b),
    .out_vld (rvalid_b),
    .out_data(rdata_b)
  );

endmodule

// File: doc/tdp_ram_be.md
Name: tdp_ram_be

Overview:
- Parametrised true dual-port synchronous RAM with per-byte write enables and a selectable read-during-write mode.
- Optional registered output stage with read-valid strobes.
- Deterministic same-address collision resolution, plus a collision flag and a saturating collision counter.
- General-purpose storage block for datapath buffers; replaces the fixed 8x128 dual-port RAM.

Parameters:
- DATA_W, 128, word width in bits; must be a multiple of 8.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- RDW_MODE, 0, 0 = READ_FIRST (read returns the pre-write word), 1 = WRITE_FIRST (read returns the post-write word).
- OUT_REG, 0, 1 adds a second output register stage.
- PRIO_A, 1, 1 = port A wins bytes written by both ports in the same cycle; 0 = port B wins.
- CNT_W, 16, collision counter width.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- en_a  in  1  port A access enable.
- we_a  in  1  port A write enable; qualified by en_a.
- be_a  in  DATA_W/8  port A byte enables; bit i covers data[8i+7:8i].
- addr_a  in  ADDR_W  port A address.
- wdata_a  in  DATA_W  port A write data.
- rdata_a  out  DATA_W  port A read data.
- rvalid_a  out  1  port A read data valid.
- en_b, we_b, be_b, addr_b, wdata_b, rdata_b, rvalid_b: identical set for port B.
- collision  out  1  one-cycle pulse flagging a same-address conflict.
- coll_cnt  out  CNT_W  saturating count of collisions.
- clr_cnt  in  1  synchronous clear of coll_cnt.

Behaviour:
- Reset: asynchronously clears rdata_a, rdata_b, rvalid_a, rvalid_b, collision and coll_cnt to 0, plus all internal pipeline registers. Memory contents are not reset.
- Access: every access with en_x=1 is a read. If we_x=1 it is also a write.
- Byte enables: only bytes with be_x[i]=1 are written. we_x=1 with be_x=0 writes nothing but still reads.
- Read latency:
  - OUT_REG=0: rdata_x and rvalid_x are valid 1 cycle after en_x.
  - OUT_REG=1: valid 2 cycles after en_x.
- Valid strobe: rvalid_x=1 for exactly one cycle per accepted access. rdata_x holds its value when rvalid_x=0.
- Same-address writes (both ports write addr_a==addr_b in one cycle), merged per byte:
  - byte enabled by one port only: that port's byte is written;
  - byte enabled by both ports: the PRIO_A winner's byte is written;
  - byte enabled by neither: unchanged.
- Read-during-write (any port reads an address written in the same cycle by either port):
  - RDW_MODE=0: returns the word as it was before the cycle.
  - RDW_MODE=1: returns the fully merged word after the cycle's writes.
  - Applies identically to same-port and cross-port cases.
- Collision condition: en_a & en_b & (addr_a==addr_b) & (we_a | we_b).
  - collision pulses 1 in the cycle after the condition.
  - coll_cnt increments in that same cycle and saturates at 2**CNT_W-1 (no wrap).
  - Two reads to the same address are not a collision.
- clr_cnt=1: coll_cnt becomes 0 next cycle; clear takes priority over a simultaneous increment.
- Reset mid-operation: in-flight reads are dropped, so no rvalid is emitted after reset deasserts for accesses issued before reset. A write presented in the cycle reset asserts is not guaranteed.
- Addresses: always in range; no wrap logic needed.

Decomposition:
- Package tdp_ram_pkg holds:
  - rdw_mode_e enum (READ_FIRST=0, WRITE_FIRST=1);
  - function nbytes(DATA_W);
  - function byte_merge(old, wdata, be), returning the per-byte masked word.
- Sub-module tdp_ram_outpipe handles the per-port rdata/rvalid pipeline with the OUT_REG stage; instantiate it twice.
- Memory array, write merge and collision logic stay in the top level.

Test Plan (defaults unless stated; all-ones be is written 0xFFFF):
- Basic write/read: write A addr 2 = 0x0123..EF with be=0xFFFF; next cycle read B addr 2 -> rdata_b=0x0123..EF with rvalid_b=1 one cycle later (two cycles with OUT_REG=1).
- Byte enables: addr 5 holds 0; A writes 0xFF..FF with be=0x000F -> read returns low 4 bytes 0xFFFFFFFF, upper 12 bytes 0.
- Dual-write collision (PRIO_A=1):
  - A writes all-0xAA with be=0x00FF and B writes all-0x55 with be=0x0FF0 to addr 1;
  - read -> bytes 0-7 = 0xAA, bytes 8-11 = 0x55, bytes 12-15 unchanged;
  - collision pulses once; coll_cnt=1.
- RDW modes: addr 3 = 0x11..11; A writes 0x22..22 while B reads addr 3 -> rdata_b=0x11..11 with RDW_MODE=0, and 0x22..22 with RDW_MODE=1.
- Counter: CNT_W=2; 5 consecutive colliding cycles -> coll_cnt saturates at 3. clr_cnt together with a collision -> coll_cnt=0. Same-address read/read -> no collision pulse.
- Async reset: assert rst_n=0 mid-cycle with reads in flight -> outputs 0 immediately; after release no rvalid appears; memory retains contents previously written.
